// File: rtl/wb_slave_decoder.sv
// rtl/wb_slave_decoder.sv - Wishbone classic address decoder with registered grant, response mux and ack timeout
module wb_slave_decoder #(
   parameter int NUM_SLAVES = 8,
   parameter int ADDR_WIDTH = 40,
   parameter int DATA_WIDTH = 64,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_BASE = '0,
   parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLV_MASK = '0,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                             sys_clock_i,
   input  logic                             sys_reset_i,
   input  logic                             wbs_cycle_i,
   input  logic                             wbs_strobe_i,
   input  logic                             wbs_we_i,
   input  logic [ADDR_WIDTH-1:0]            wbs_addr_i,
   input  logic [DATA_WIDTH-1:0]            wbs_data_i,
   input  logic [DATA_WIDTH/8-1:0]          wbs_sel_i,
   output logic [DATA_WIDTH-1:0]            wbs_data_o,
   output logic                             wbs_ack_o,
   output logic                             wbs_err_o,
   output logic [NUM_SLAVES-1:0]            wbm_cycle_o,
   output logic [NUM_SLAVES-1:0]            wbm_strobe_o,
   input  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbm_data_i,
   input  logic [NUM_SLAVES-1:0]            wbm_ack_i,
   output logic [ADDR_WIDTH-1:0]            err_addr_o,
   output logic [15:0]                      err_count_o
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACTIVE,
      ST_ERROR
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES);

   state_t                  state_q, state_d;
   logic [NUM_SLAVES-1:0]   grant_q, grant_d;
   logic [15:0]             tmo_cnt_q, tmo_cnt_d;
   logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
   logic [15:0]             err_count_q, err_count_d;

   logic [NUM_SLAVES-1:0]   match_onehot;
   logic                    match_any;
   logic [DATA_WIDTH-1:0]   rdata;
   logic                    active;
   logic                    ack_hit;
   logic                    tmo_expire;

   // Write data, select and we are broadcast to the slaves outside this block
   logic unused_inputs;
   assign unused_inputs = ^{wbs_we_i, wbs_data_i, wbs_sel_i};

   // Address decode: first slave (lowest index) whose compared bits match wins
   always_comb begin
      match_onehot = '0;
      match_any    = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (!match_any &&
             (((wbs_addr_i ^ SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) &
               SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == '0)) begin
            match_onehot[i] = 1'b1;
            match_any       = 1'b1;
         end
      end
   end

   // Read data mux: grant is one-hot, so OR-ing the gated lanes selects one slave
   always_comb begin
      rdata = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (grant_q[i]) begin
            rdata = rdata | wbm_data_i[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign active     = (state_q == ST_ACTIVE);
   assign ack_hit    = active && (|(grant_q & wbm_ack_i));
   assign tmo_expire = ((tmo_cnt_q + 16'd1) == TMO_LAST);

   assign wbm_cycle_o  = active ? (grant_q & {NUM_SLAVES{wbs_cycle_i}})  : '0;
   assign wbm_strobe_o = active ? (grant_q & {NUM_SLAVES{wbs_strobe_i}}) : '0;
   assign wbs_ack_o    = ack_hit;
   assign wbs_err_o    = (state_q == ST_ERROR);
   assign wbs_data_o   = active ? rdata : '0;
   assign err_addr_o   = err_addr_q;
   assign err_count_o  = err_count_q;

   // Next-state logic: decode in IDLE, wait for ack/abort/timeout in ACTIVE, one-cycle ERROR
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      tmo_cnt_d   = tmo_cnt_q;
      err_addr_d  = err_addr_q;
      err_count_d = err_count_q;
      case (state_q)
         ST_IDLE: begin
            tmo_cnt_d = '0;
            if (wbs_cycle_i && wbs_strobe_i) begin
               if (match_any) begin
                  grant_d = match_onehot;
                  state_d = ST_ACTIVE;
               end else begin
                  grant_d = '0;
                  state_d = ST_ERROR;
               end
            end
         end
         ST_ACTIVE: begin
            // Ack is checked first so a late ack on the timeout cycle still completes
            if (ack_hit || !wbs_cycle_i) begin
               grant_d   = '0;
               tmo_cnt_d = '0;
               state_d   = ST_IDLE;
            end else if (tmo_expire) begin
               grant_d   = '0;
               tmo_cnt_d = '0;
               state_d   = ST_ERROR;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         ST_ERROR: begin
            err_addr_d = wbs_addr_i;
            if (err_count_q != 16'hFFFF) begin
               err_count_d = err_count_q + 16'd1;
            end
            state_d = ST_IDLE;
         end
         default: begin
            grant_d   = '0;
            tmo_cnt_d = '0;
            state_d   = ST_IDLE;
         end
      endcase
   end

   // State and error bookkeeping registers, cleared asynchronously
   always_ff @(posedge sys_clock_i or negedge sys_reset_i) begin
      if (!sys_reset_i) begin
         state_q     <= ST_IDLE;
         grant_q     <= '0;
         tmo_cnt_q   <= '0;
         err_addr_q  <= '0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         tmo_cnt_q   <= tmo_cnt_d;
         err_addr_q  <= err_addr_d;
         err_count_q <= err_count_d;
      end
   end

endmodule

// File: tb/tb_wb_slave_decoder.sv
// tb/tb_wb_slave_decoder.sv - directed and randomized bench for wb_slave_decoder
module tb_wb_slave_decoder;

   localparam int N  = 8;
   localparam int AW = 40;
   localparam int DW = 64;
   localparam int SW = DW / 8;
   localparam int T  = 4;

   // Instance A has a catch-all slave 5; instance B has no default slave
   localparam logic [N*AW-1:0] BASE_A = {40'h77_0000_0000, 40'h66_0000_0000, 40'h00_0000_0000, 40'h22_0000_0000,
                                         40'h11_3000_0000, 40'h11_3000_0000, 40'h00_0005_0000, 40'h00_0004_0000};
   localparam logic [N*AW-1:0] MASK_A = {40'hFF_0000_0000, 40'hFF_F000_0000, 40'h00_0000_0000, 40'hFF_0000_0000,
                                         40'hFF_FF00_0000, 40'hFF_FFFF_0000, 40'hFF_FFFF_0000, 40'hFF_FFFF_0000};
   localparam logic [N*AW-1:0] BASE_B = {40'h77_0000_0000, 40'h66_0000_0000, 40'h55_0000_0000, 40'h22_0000_0000,
                                         40'h11_3000_0000, 40'h11_3000_0000, 40'h00_0005_0000, 40'h00_0004_0000};
   localparam logic [N*AW-1:0] MASK_B = {40'hFF_0000_0000, 40'hFF_F000_0000, 40'hFF_0000_0000, 40'hFF_0000_0000,
                                         40'hFF_FF00_0000, 40'hFF_FFFF_0000, 40'hFF_FFFF_0000, 40'hFF_FFFF_0000};

   logic clk = 1'b0;
   logic rst_n;
   logic [1:0]          cyc, stb, we;
   logic [1:0][AW-1:0]  addr;
   logic [DW-1:0]       wdat;
   logic [SW-1:0]       sel;
   logic [1:0][DW-1:0]  rdata;
   logic [1:0]          ack, err;
   logic [1:0][N-1:0]   mcyc, mstb, slv_ack, stray, ack_in;
   logic [1:0][AW-1:0]  eaddr;
   logic [1:0][15:0]    ecnt;
   logic [N*DW-1:0]     data_bus;
   logic [DW-1:0]       sdata [N];
   int                  lat [N];
   int                  wcnt [2][N];

   logic [AW-1:0] base_t [2][N];
   logic [AW-1:0] mask_t [2][N];
   logic [15:0]   exp_cnt [2];
   logic [AW-1:0] exp_eaddr [2];

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   always_comb begin
      data_bus = '0;
      for (int i = 0; i < N; i++) data_bus[i*DW +: DW] = sdata[i];
   end

   assign ack_in[0] = slv_ack[0] | stray[0];
   assign ack_in[1] = slv_ack[1] | stray[1];

   // Slave model: acks lat[i] cycles after its strobe first appears (lat 0 = never)
   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!rst_n || !mstb[k][i]) begin
               wcnt[k][i]    <= 0;
               slv_ack[k][i] <= 1'b0;
            end else begin
               wcnt[k][i]    <= wcnt[k][i] + 1;
               slv_ack[k][i] <= (lat[i] != 0) && (wcnt[k][i] + 1 == lat[i]);
            end
         end
      end
   end

   wb_slave_decoder #(.NUM_SLAVES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .SLV_BASE(BASE_A), .SLV_MASK(MASK_A), .TIMEOUT_CYCLES(T)) dut_a (
      .sys_clock_i(clk), .sys_reset_i(rst_n),
      .wbs_cycle_i(cyc[0]), .wbs_strobe_i(stb[0]), .wbs_we_i(we[0]),
      .wbs_addr_i(addr[0]), .wbs_data_i(wdat), .wbs_sel_i(sel),
      .wbs_data_o(rdata[0]), .wbs_ack_o(ack[0]), .wbs_err_o(err[0]),
      .wbm_cycle_o(mcyc[0]), .wbm_strobe_o(mstb[0]),
      .wbm_data_i(data_bus), .wbm_ack_i(ack_in[0]),
      .err_addr_o(eaddr[0]), .err_count_o(ecnt[0]));

   wb_slave_decoder #(.NUM_SLAVES(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                      .SLV_BASE(BASE_B), .SLV_MASK(MASK_B), .TIMEOUT_CYCLES(T)) dut_b (
      .sys_clock_i(clk), .sys_reset_i(rst_n),
      .wbs_cycle_i(cyc[1]), .wbs_strobe_i(stb[1]), .wbs_we_i(we[1]),
      .wbs_addr_i(addr[1]), .wbs_data_i(wdat), .wbs_sel_i(sel),
      .wbs_data_o(rdata[1]), .wbs_ack_o(ack[1]), .wbs_err_o(err[1]),
      .wbm_cycle_o(mcyc[1]), .wbm_strobe_o(mstb[1]),
      .wbm_data_i(data_bus), .wbm_ack_i(ack_in[1]),
      .err_addr_o(eaddr[1]), .err_count_o(ecnt[1]));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: an address belongs to slave i when it falls inside that slave's window
   function automatic int decode(input int k, input logic [AW-1:0] a);
      for (int i = 0; i < N; i++) begin
         if ((a & mask_t[k][i]) == (base_t[k][i] & mask_t[k][i])) return i;
      end
      return -1;
   endfunction

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic check_quiet(input int k, input string tag);
      chk({tag, "_stb"}, mstb[k], 0);
      chk({tag, "_cyc"}, mcyc[k], 0);
      chk({tag, "_ack"}, ack[k], 0);
      chk({tag, "_err"}, err[k], 0);
      chk({tag, "_data"}, rdata[k], 0);
   endtask

   // One complete master access on instance k, checked cycle by cycle against the reference
   task automatic access(input int k, input logic [AW-1:0] a);
      int idx, l, n;
      bit done;
      logic [N-1:0] oh;
      idx = decode(k, a);
      l   = (idx >= 0) ? lat[idx] : 0;
      oh  = (idx >= 0) ? N'(1 << idx) : '0;
      @(posedge clk); #1;
      cyc[k] = 1'b1; stb[k] = 1'b1; addr[k] = a; we[k] = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_quiet(k, "decode");
      n = 0; done = 1'b0;
      while (!done) begin
         @(negedge clk);
         n++;
         if (idx < 0 || n == T + 1) begin
            chk("err_pulse", err[k], 1);
            chk("err_stb", mstb[k], 0);
            chk("err_ack", ack[k], 0);
            exp_cnt[k]   = sat_inc(exp_cnt[k]);
            exp_eaddr[k] = a;
            done = 1'b1;
         end else begin
            chk("act_stb", mstb[k], oh);
            chk("act_cyc", mcyc[k], oh);
            chk("act_err", err[k], 0);
            chk("act_data", rdata[k], sdata[idx]);
            if (l != 0 && n == l + 1) begin
               chk("act_ack", ack[k], 1);
               done = 1'b1;
            end else begin
               chk("act_noack", ack[k], 0);
            end
         end
      end
      @(posedge clk); #1;
      cyc[k] = 1'b0; stb[k] = 1'b0;
      @(negedge clk);
      check_quiet(k, "after");
      chk("err_count", ecnt[k], exp_cnt[k]);
      chk("err_addr", eaddr[k], exp_eaddr[k]);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [AW-1:0] ra, rv;
      int j;
      for (int i = 0; i < N; i++) begin
         base_t[0][i] = BASE_A[i*AW +: AW];
         mask_t[0][i] = MASK_A[i*AW +: AW];
         base_t[1][i] = BASE_B[i*AW +: AW];
         mask_t[1][i] = MASK_B[i*AW +: AW];
         sdata[i] = {$urandom, $urandom};
         lat[i]   = 1;
      end
      cyc = '0; stb = '0; we = '0; addr = '0; stray = '0;
      wdat = 64'h0123_4567_89AB_CDEF; sel = '1;
      exp_cnt[0] = '0; exp_cnt[1] = '0; exp_eaddr[0] = '0; exp_eaddr[1] = '0;

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         check_quiet(k, "reset");
         chk("reset_err_addr", eaddr[k], 0);
         chk("reset_err_count", ecnt[k], 0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Basic read to slave 0 with one-cycle slave latency, on both instances
      access(0, 40'h00_0004_0008);
      access(1, 40'h00_0004_0008);

      // Overlapping windows: lower index wins, unmatched falls to the catch-all
      access(0, 40'h11_3000_0010);
      access(0, 40'h20_0000_0000);
      access(0, 40'h11_3100_0000);

      // Unmapped address on the instance without a default slave
      access(1, 40'hAB_CDE0_0000);

      // Silent slave times out; a stray ack from another slave must not leak through
      lat[0] = 0;
      stray[0] = 8'h02;
      access(0, 40'h00_0004_0100);
      stray[0] = '0;
      lat[0] = 1;
      access(1, 40'h00_0004_0200);

      // Ack arriving on the last allowed cycle beats the timeout
      lat[4] = T - 1;
      access(0, 40'h22_0000_1234);
      lat[4] = 1;

      // Master abandons the cycle on the second ACTIVE cycle
      lat[0] = 0;
      @(posedge clk); #1;
      cyc[0] = 1'b1; stb[0] = 1'b1; addr[0] = 40'h00_0004_0008;
      @(negedge clk);
      check_quiet(0, "abort_decode");
      @(negedge clk);
      chk("abort_act1_stb", mstb[0], 8'h01);
      @(posedge clk); #1;
      cyc[0] = 1'b0; stb[0] = 1'b0;
      @(negedge clk);
      chk("abort_act2_cyc", mcyc[0], 0);
      chk("abort_act2_err", err[0], 0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check_quiet(0, "abort_idle");
      end
      chk("abort_err_count", ecnt[0], exp_cnt[0]);
      lat[0] = 1;

      // Randomized accesses across both instances
      for (int r = 0; r < 60; r++) begin
         j = int'($urandom_range(0, 1));
         for (int i = 0; i < N; i++) begin
            lat[i]   = int'($urandom_range(0, 5));
            sdata[i] = {$urandom, $urandom};
         end
         rv = AW'({$urandom, $urandom});
         if ($urandom_range(0, 3) == 0) begin
            ra = rv;
         end else begin
            int s;
            s  = int'($urandom_range(0, N - 1));
            ra = (base_t[j][s] & mask_t[j][s]) | (rv & ~mask_t[j][s]);
         end
         access(j, ra);
      end

      // Error counter saturation: preload near the top, then keep erroring
      @(posedge clk); #1;
      force dut_b.err_count_q = 16'hFFFD;
      #1;
      release dut_b.err_count_q;
      exp_cnt[1] = 16'hFFFD;
      for (int e = 0; e < 4; e++) begin
         access(1, 40'h99_0000_0000 + AW'(e));
      end
      chk("sat_final", ecnt[1], 16'hFFFF);

      // Asynchronous reset in the middle of an ACTIVE cycle
      lat[0] = 0;
      @(posedge clk); #1;
      cyc[0] = 1'b1; stb[0] = 1'b1; addr[0] = 40'h00_0004_0008;
      @(posedge clk); #3;
      chk("pre_reset_stb", mstb[0], 8'h01);
      rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check_quiet(k, "async_reset");
         chk("async_reset_err_count", ecnt[k], 0);
         chk("async_reset_err_addr", eaddr[k], 0);
      end
      cyc[0] = 1'b0; stb[0] = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      exp_cnt[0] = '0; exp_cnt[1] = '0; exp_eaddr[0] = '0; exp_eaddr[1] = '0;
      lat[0] = 1;
      access(0, 40'h00_0004_0008);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_slave_decoder.md
Name: wb_slave_decoder

Overview:
- Parametrised Wishbone classic address decoder and response multiplexer.
- Sits between the S1 Wishbone master port and NUM_SLAVES memory harnesses or peripherals.
- Replaces hard-wired per-bank cycle/strobe gating and ack OR-ing with a registered grant, per-slave base/mask decode, a gated data mux and an ack timeout.
- Unmapped or hung accesses terminate with a bus error instead of stalling the core.

Parameters:
- NUM_SLAVES, 8, number of slave channels (1..16).
- ADDR_WIDTH, 40, Wishbone address width.
- DATA_WIDTH, 64, Wishbone data width; select width is DATA_WIDTH/8.
- SLV_BASE, 0, packed NUM_SLAVES*ADDR_WIDTH; slave i base address in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- SLV_MASK, 0, packed NUM_SLAVES*ADDR_WIDTH; a set bit means that address bit is compared.
- TIMEOUT_CYCLES, 255, cycles in ACTIVE without ack before a bus error (1..65535).

Ports:
- sys_clock_i  in  1  clock; all logic on the rising edge.
- sys_reset_i  in  1  reset, asynchronous, active-low.
- wbs_cycle_i  in  1  master cycle.
- wbs_strobe_i  in  1  master strobe.
- wbs_we_i  in  1  master write enable.
- wbs_addr_i  in  ADDR_WIDTH  master address.
- wbs_data_i  in  DATA_WIDTH  master write data.
- wbs_sel_i  in  DATA_WIDTH/8  master byte select.
- wbs_data_o  out  DATA_WIDTH  read data to master.
- wbs_ack_o  out  1  ack to master.
- wbs_err_o  out  1  bus error to master.
- wbm_cycle_o  out  NUM_SLAVES  per-slave cycle.
- wbm_strobe_o  out  NUM_SLAVES  per-slave strobe.
- wbm_data_i  in  NUM_SLAVES*DATA_WIDTH  packed slave read data.
- wbm_ack_i  in  NUM_SLAVES  per-slave ack.
- err_addr_o  out  ADDR_WIDTH  address of the most recent errored access.
- err_count_o  out  16  errored-access count, saturating at 16'hFFFF.

Note: slave address, write data, sel and we are broadcast outside this block from the wbs_* inputs.

Behaviour:
- Reset (sys_reset_i low, asynchronous): state IDLE, grant one-hot cleared, timeout counter 0, err_addr_o 0, err_count_o 0. All outputs 0: wbs_ack_o, wbs_err_o, wbs_data_o, wbm_cycle_o, wbm_strobe_o.
- Decode is combinational. Slave i matches when ((wbs_addr_i ^ base_i) & mask_i) == 0.
  - Multiple matches: the lowest index wins.
  - A slave whose mask is all-zero matches every address and acts as the default.
- FSM states: IDLE, ACTIVE, ERROR.
  - IDLE: on wbs_cycle_i & wbs_strobe_i, register the grant and go to ACTIVE if any slave matches; otherwise go to ERROR. No slave strobe is driven in this decode cycle (fixed one-cycle decode latency).
  - ACTIVE: wbm_cycle_o = grant & wbs_cycle_i and wbm_strobe_o = grant & wbs_strobe_i. wbs_ack_o = |(grant & wbm_ack_i), passed combinationally the same cycle. wbs_data_o = data of the granted slave, else 0.
    - On ack: return to IDLE, clear the grant and the counter. A back-to-back access therefore costs decode plus slave latency.
    - Acks from non-granted slaves are ignored: they never reach wbs_ack_o.
    - The counter increments each ACTIVE cycle without ack. On reaching TIMEOUT_CYCLES, go to ERROR, and slave cycle/strobe drop the next cycle.
    - If the master deasserts wbs_cycle_i, abort to IDLE the next cycle. No error is raised and err_count_o is unchanged.
    - If ack and timeout occur in the same cycle, the ack wins and no error is raised.
  - ERROR: wbs_err_o = 1 for exactly one cycle, wbs_ack_o = 0, all wbm_cycle_o/wbm_strobe_o = 0.
    - err_addr_o latches wbs_addr_i and err_count_o increments (saturating).
    - Next state is always IDLE.
- wbs_ack_o and wbs_err_o are never asserted together.
- Reset asserted mid-transaction returns to IDLE immediately and drops all slave strobes. Error registers clear.

Test Plan:
- Slave 0 base 0x0000040000, mask 0xFFFFFF0000, slave acks 1 cycle after strobe, master read at 0x0000040008 -> wbm_strobe_o = 8'h01 from cycle 2; wbs_ack_o in cycle 3; wbs_data_o equals slave 0 data; FSM back in IDLE in cycle 4.
- Overlap: slave 2 base 0x1130000000 mask 0xFFFFFF0000 and slave 5 all-zero mask, access 0x1130000010 -> only bit 2 strobed. Access 0x2000000000 -> only bit 5 strobed.
- No all-zero-mask slave, access 0xABCDE00000 -> wbs_err_o pulses 1 cycle after the decode cycle; err_addr_o = 0xABCDE00000; err_count_o = 1; no wbm_strobe_o bit set.
- TIMEOUT_CYCLES = 4, granted slave never acks -> wbs_err_o after 4 ACTIVE cycles; strobe low afterwards; err_count_o increments. Also, a stray ack from a non-granted slave during the wait -> wbs_ack_o stays 0.
- Master drops wbs_cycle_i on the 2nd ACTIVE cycle -> IDLE next cycle, wbs_err_o = 0, err_count_o unchanged. Also, async reset pulsed mid-ACTIVE -> all outputs 0 immediately.
- Force 65536 errors -> err_count_o saturates at 16'hFFFF and does not wrap.
